sdp_scan_driver: RTL and testbench

//   Time-multiplexed scan controller for the 8-digit seven-segment display.

---
 rtl/sdp_scan_driver.sv | 120 ++++++++++++
 tb/tb_sdp_scan_driver.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/sdp_scan_driver.sv
// Eight-digit seven-segment scan controller: steps the digit index at a fixed
// slot rate, blanks the start of each slot, and double-buffers the shown value.
module sdp_scan_driver #(
    parameter int DIV   = 50000,
    parameter int BLANK = 500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data,
    input  logic [7:0]  dp_in,
    input  logic [7:0]  en_mask,
    input  logic        load,
    output logic [2:0]  sel,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done
);

    localparam int            PW      = $clog2(DIV);
    localparam logic [PW-1:0] P_LAST  = PW'(DIV - 1);
    localparam logic [PW-1:0] P_BLANK = PW'(BLANK);

    typedef struct packed {
        logic [31:0] data;
        logic [7:0]  dp;
        logic [7:0]  mask;
    } disp_t;

    logic [PW-1:0] p_q, p_d;
    logic [2:0]    d_q, d_d;
    disp_t         shadow_q, shadow_d;
    disp_t         active_q, active_d;
    logic          pending_q, pending_d;
    logic          frame_done_q, frame_done_d;

    logic          slot_end;
    logic          boundary;
    disp_t         live;
    logic [3:0]    nibble;
    logic          blank;

    function automatic logic [6:0] hex_seg(input logic [3:0] v);
        case (v)
            4'h0: hex_seg = 7'h40;
            4'h1: hex_seg = 7'h79;
            4'h2: hex_seg = 7'h24;
            4'h3: hex_seg = 7'h30;
            4'h4: hex_seg = 7'h19;
            4'h5: hex_seg = 7'h12;
            4'h6: hex_seg = 7'h02;
            4'h7: hex_seg = 7'h78;
            4'h8: hex_seg = 7'h00;
            4'h9: hex_seg = 7'h10;
            4'hA: hex_seg = 7'h08;
            4'hB: hex_seg = 7'h03;
            4'hC: hex_seg = 7'h46;
            4'hD: hex_seg = 7'h21;
            4'hE: hex_seg = 7'h06;
            default: hex_seg = 7'h0E;
        endcase
    endfunction

    always_comb begin
        // NOTE: every _d gets a default before any branch so no latch is inferred.
        slot_end     = (p_q == P_LAST);
        boundary     = slot_end && (d_q == 3'd7);
        live         = '{data: data, dp: dp_in, mask: en_mask};
        p_d          = slot_end ? '0 : p_q + 1'b1;
        d_d          = slot_end ? d_q + 3'd1 : d_q;
        shadow_d     = shadow_q;
        active_d     = active_q;
        pending_d    = pending_q;
        frame_done_d = boundary;

        if (load) begin
            shadow_d  = live;
            pending_d = 1'b1;
        end
        // A load on the boundary edge itself bypasses the shadow.
        if (boundary) begin
            if (load) begin
                active_d = live;
            end else if (pending_q) begin
                active_d = shadow_q;
            end
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all update together.
        if (rst) begin
            p_q          <= '0;
            d_q          <= '0;
            shadow_q     <= '0;
            active_q     <= '0;
            pending_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            p_q          <= p_d;
            d_q          <= d_d;
            shadow_q     <= shadow_d;
            active_q     <= active_d;
            pending_q    <= pending_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Outputs depend on registers only; sel and seg move on the same edge.
    always_comb begin
        nibble = active_q.data[{d_q, 2'b00} +: 4];
        blank  = (p_q < P_BLANK) || !active_q.mask[d_q];
        seg    = blank ? 7'h7F : hex_seg(nibble);
        dp     = blank | ~active_q.dp[d_q];
    end

    assign sel        = d_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sdp_scan_driver.sv
// Self-checking bench for sdp_scan_driver: a time-based reference model checked
// every cycle, plus literal expectations at hand-picked scan positions.
module tb_sdp_scan_driver;

    localparam int DIV   = 4;
    localparam int BLANK = 1;
    localparam int FRAME = 8 * DIV;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] data;
    logic [7:0]  dp_in;
    logic [7:0]  en_mask;
    logic        load;
    logic [2:0]  sel;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    int n_tests = 0;
    int n_fail  = 0;

    sdp_scan_driver #(.DIV(DIV), .BLANK(BLANK)) dut (
        .clk        (clk),
        .rst        (rst),
        .data       (data),
        .dp_in      (dp_in),
        .en_mask    (en_mask),
        .load       (load),
        .sel        (sel),
        .seg        (seg),
        .dp         (dp),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Reference model: position derives from cycles elapsed since reset.
    logic [6:0]  hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    int          m_t     = 0;
    bit          m_valid = 0;
    bit          m_pending;
    bit          m_fd;
    logic [31:0] m_sh_data, m_ac_data;
    logic [7:0]  m_sh_dp, m_ac_dp, m_sh_mask, m_ac_mask;

    always @(posedge clk) begin
        if (rst) begin
            m_t = 0; m_valid = 1; m_pending = 0; m_fd = 0;
            m_sh_data = 0; m_sh_dp = 0; m_sh_mask = 0;
            m_ac_data = 0; m_ac_dp = 0; m_ac_mask = 0;
        end else if (m_valid) begin
            bit bnd;
            bnd = (m_t % FRAME) == FRAME - 1;
            if (load) begin
                m_sh_data = data; m_sh_dp = dp_in; m_sh_mask = en_mask; m_pending = 1;
            end
            if (bnd) begin
                if (m_pending) begin
                    m_ac_data = m_sh_data; m_ac_dp = m_sh_dp; m_ac_mask = m_sh_mask;
                end
                m_pending = 0;
            end
            m_fd = bnd;
            m_t++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0d)", name, act, exp, m_t);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            int  p, d;
            bit  blk;
            logic [3:0] nib;
            p   = m_t % DIV;
            d   = (m_t / DIV) % 8;
            blk = (p < BLANK) || !m_ac_mask[d];
            nib = m_ac_data[d*4 +: 4];
            check("model_sel", 32'(sel), 32'(d));
            check("model_seg", 32'(seg), blk ? 32'h7F : 32'(hex_tab[nib]));
            check("model_dp", 32'(dp), blk ? 32'd1 : 32'(!m_ac_dp[d]));
            check("model_frame_done", 32'(frame_done), 32'(m_fd));
        end
    end

    task automatic wait_t(input int n);
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (m_t == n) return;
        end
        n_tests++;
        n_fail++;
        $display("FAIL wait_t: t=%0d, expected to reach %0d", m_t, n);
    endtask

    task automatic pulse_load(input logic [31:0] v, input logic [7:0] m, input logic [7:0] pt);
        data = v; en_mask = m; dp_in = pt; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; data = '0; dp_in = '0; en_mask = '0;
        repeat (3) @(negedge clk);
        check("rst_seg", 32'(seg), 32'h7F);
        check("rst_dp", 32'(dp), 32'd1);

        // Scan and blanking
        rst = 1'b0;
        pulse_load(32'h76543210, 8'hFF, 8'h00);
        check("pre_boundary_blank", 32'(seg), 32'h7F);
        check("no_fd_from_reset", 32'(frame_done), 32'd0);
        wait_t(32);
        check("fd_first_frame", 32'(frame_done), 32'd1);
        check("slot0_blank", 32'(seg), 32'h7F);
        wait_t(41);
        check("sel2", 32'(sel), 32'd2);
        check("digit2_seg", 32'(seg), 32'h24);

        // Double buffering: load during digit 3
        wait_t(45);
        pulse_load(32'hFFFFFFFF, 8'hFF, 8'h00);
        wait_t(61);
        check("no_tear_d7", 32'(seg), 32'h78);
        wait_t(65);
        check("new_frame_F", 32'(seg), 32'h0E);

        // Enable mask
        wait_t(70);
        pulse_load(32'h89ABCDEF, 8'h0F, 8'h00);
        wait_t(93);
        check("old_F_d7", 32'(seg), 32'h0E);
        wait_t(97);
        check("mask_d0", 32'(seg), 32'h0E);
        wait_t(105);
        check("mask_d2", 32'(seg), 32'h21);
        wait_t(109);
        check("mask_d3", 32'(seg), 32'h46);
        wait_t(113);
        check("mask_d4_off", 32'(seg), 32'h7F);
        wait_t(126);
        check("mask_d7_off", 32'(seg), 32'h7F);

        // Load on the boundary edge, with decimal point on digit 0
        wait_t(127);
        check("boundary_sel", 32'(sel), 32'd7);
        pulse_load(32'h76543210, 8'hFF, 8'h01);
        check("fd_after_wrap", 32'(frame_done), 32'd1);
        check("dp_blank_p0", 32'(dp), 32'd1);
        wait_t(129);
        check("boundary_load_seg", 32'(seg), 32'h40);
        check("dp_on_d0", 32'(dp), 32'd0);
        wait_t(133);
        check("dp_off_d1", 32'(dp), 32'd1);
        check("fd_single_cycle", 32'(frame_done), 32'd0);

        // Reset mid-slot
        wait_t(182);
        check("pre_rst_sel", 32'(sel), 32'd5);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_sel", 32'(sel), 32'd0);
        check("rst_mid_seg", 32'(seg), 32'h7F);
        check("rst_mid_dp", 32'(dp), 32'd1);
        check("rst_mid_fd", 32'(frame_done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        wait_t(33);
        check("post_rst_blank", 32'(seg), 32'h7F);
        wait_t(40);
        pulse_load(32'h01234567, 8'hFF, 8'h00);
        wait_t(65);
        check("reload_d0", 32'(seg), 32'h78);
        wait_t(69);
        check("reload_d1", 32'(seg), 32'h02);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
